// File: rtl/shr_pkg.sv
// -----------------------------------------------------------------------------
// shr_pkg
// Shared definitions for the sequential shift-right ALU op and its helpers:
// default operand width, CCR bit indices and masks (same layout as the other
// ALU ops), and the sequencer state encoding.
// -----------------------------------------------------------------------------
package shr_pkg;

    localparam int OP_SIZE_DEF = 4;

    // CCR layout: {C, V, N, Z}
    localparam int C_IDX = 3;
    localparam int V_IDX = 2;
    localparam int N_IDX = 1;
    localparam int Z_IDX = 0;

    localparam logic [3:0] C_MASK = 4'b1000;
    localparam logic [3:0] V_MASK = 4'b0100;
    localparam logic [3:0] N_MASK = 4'b0010;
    localparam logic [3:0] Z_MASK = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shr_ccr_calc.sv
// -----------------------------------------------------------------------------
// shr_ccr_calc
// Combinational condition-code generator for the ALU ops.
//   C = carry (last bit shifted out)
//   V = sign change between the original operand and the result
//   N = result MSB
//   Z = result is all zeros
// Ports:
//   a_msb  in   MSB of the original operand
//   value  in   final result value (W bits)
//   carry  in   carry / last bit shifted out
//   ccr    out  {C, V, N, Z}
// -----------------------------------------------------------------------------
module shr_ccr_calc
    import shr_pkg::*;
#(
    parameter int W = OP_SIZE_DEF
) (
    input  logic         a_msb,
    input  logic [W-1:0] value,
    input  logic         carry,
    output logic [3:0]   ccr
);

    always_comb begin
        ccr = 4'b0000;
        if (carry)                ccr = ccr | C_MASK;
        if (a_msb ^ value[W-1])   ccr = ccr | V_MASK;
        if (value[W-1])           ccr = ccr | N_MASK;
        if (value == '0)          ccr = ccr | Z_MASK;
    end

endmodule

// File: rtl/shr_seq.sv
// -----------------------------------------------------------------------------
// shr_seq
// Sequential shift-right unit: shifts A right by min(amt, OP_SIZE) positions,
// one bit per clock, in logical or arithmetic mode, then presents R and the
// CCR flags for one DONE cycle and holds them afterwards.
//
// Optional feature macro: SHR_ROTATE_EN
//   defined   : rot=1 selects rotate-right (takes priority over arith)
//   undefined : rot is ignored and no rotate logic exists
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   operation request, only looked at in IDLE
//   arith  in   0 = logical (MSB fills 0), 1 = arithmetic (MSB replicated)
//   rot    in   rotate-right select (only with SHR_ROTATE_EN)
//   amt    in   shift amount, saturated to OP_SIZE
//   A      in   operand
//   busy   out  high from the cycle after start is accepted through DONE
//   done   out  one-cycle completion pulse
//   R      out  result, valid from the done cycle, held until next completion
//   CCR    out  {C, V, N, Z}, same validity as R
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; R/CCR hold the last completed result
// SHIFT  | one shift per cycle until the latched count runs out
// DONE   | done pulse; R/CCR driven straight from the shift register
// -----------------------------------------------------------------------------
module shr_seq
    import shr_pkg::*;
#(
    parameter int OP_SIZE = OP_SIZE_DEF,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               arith,
    input  logic               rot,
    input  logic [CNT_W-1:0]   amt,
    input  logic [OP_SIZE-1:0] A,
    output logic               busy,
    output logic               done,
    output logic [OP_SIZE-1:0] R,
    output logic [3:0]         CCR
);

    state_t               state;
    state_t               state_nxt;

    logic [OP_SIZE-1:0]   sh_reg;
    logic [CNT_W-1:0]     cnt;
    logic                 carry;
    logic                 a_msb;
    logic                 arith_q;
    logic [OP_SIZE-1:0]   r_q;
    logic [3:0]           ccr_q;
    logic [3:0]           ccr_now;
    logic [CNT_W-1:0]     amt_sat;
    logic                 fill;

`ifdef SHR_ROTATE_EN
    logic                 rot_q;
`else
    logic                 unused_rot;
    assign unused_rot = rot;
`endif

    assign amt_sat = (amt > CNT_W'(OP_SIZE)) ? CNT_W'(OP_SIZE) : amt;

    // MSB fill for the next shift; rotate wins over arithmetic
    always_comb begin
        fill = 1'b0;
        if (arith_q) fill = sh_reg[OP_SIZE-1];
`ifdef SHR_ROTATE_EN
        if (rot_q)   fill = sh_reg[0];
`endif
    end

    shr_ccr_calc #(
        .W (OP_SIZE)
    ) u_ccr (
        .a_msb (a_msb),
        .value (sh_reg),
        .carry (carry),
        .ccr   (ccr_now)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = (amt_sat != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // During DONE the live register feeds the outputs so the result is visible
    // in the pulse cycle; the captured copy takes over from IDLE onwards.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
        R    = done ? sh_reg  : r_q;
        CCR  = done ? ccr_now : ccr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_reg  <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            a_msb   <= 1'b0;
            arith_q <= 1'b0;
            r_q     <= '0;
            ccr_q   <= 4'b0000;
`ifdef SHR_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sh_reg  <= A;
                        cnt     <= amt_sat;
                        carry   <= 1'b0;
                        a_msb   <= A[OP_SIZE-1];
                        arith_q <= arith;
`ifdef SHR_ROTATE_EN
                        rot_q   <= rot;
`endif
                    end
                end
                ST_SHIFT: begin
                    carry  <= sh_reg[0];
                    sh_reg <= {fill, sh_reg[OP_SIZE-1:1]};
                    cnt    <= cnt - CNT_W'(1);
                end
                ST_DONE: begin
                    r_q   <= sh_reg;
                    ccr_q <= ccr_now;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shr_seq.sv
module tb_shr_seq;

    localparam int OP_SIZE = 4;
    localparam int CNT_W   = 3;

`ifdef SHR_ROTATE_EN
    localparam bit ROT_ON = 1'b1;
`else
    localparam bit ROT_ON = 1'b0;
`endif

    logic               clk   = 1'b0;
    logic               rst   = 1'b1;
    logic               start = 1'b0;
    logic               arith = 1'b0;
    logic               rot   = 1'b0;
    logic [CNT_W-1:0]   amt   = '0;
    logic [OP_SIZE-1:0] A     = '0;
    logic               busy;
    logic               done;
    logic [OP_SIZE-1:0] R;
    logic [3:0]         CCR;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] r;
        logic [3:0] ccr;
        int         lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    shr_seq #(
        .OP_SIZE (OP_SIZE),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .arith (arith),
        .rot   (rot),
        .amt   (amt),
        .A     (A),
        .busy  (busy),
        .done  (done),
        .R     (R),
        .CCR   (CCR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Closed-form reference: whole-word shift instead of bit-by-bit stepping
    function automatic exp_t model(input logic [3:0] a, input logic [2:0] n,
                                   input logic ar, input logic rt);
        exp_t       e;
        int         k;
        logic [3:0] r;
        logic       c;
        k = (n > 3'd4) ? 4 : int'(n);
        if (ar) r = 4'($signed(a) >>> k);
        else    r = a >> k;
        if (ROT_ON && rt) r = 4'((a >> k) | (a << (4 - k)));
        c = (k == 0) ? 1'b0 : a[k-1];
        e.r   = r;
        e.ccr = {c, a[3] ^ r[3], r[3], (r == 4'b0000)};
        e.lat = k + 1;
        return e;
    endfunction

    // Called on a negedge; returns on the negedge of the IDLE cycle after done,
    // so consecutive calls issue start back-to-back.
    task automatic do_op(input string tag, input logic [3:0] a, input logic [2:0] n,
                         input logic ar, input logic rt, input bit disturb);
        int   cyc;
        bit   got;
        exp_t x;
        sb.push_back(model(a, n, ar, rt));
        A = a; amt = n; arith = ar; rot = rt; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc   = 1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (disturb) begin
            // new request while busy, held through the DONE cycle
            A = ~a; amt = 3'd0; arith = ~ar; rot = ~rt; start = 1'b1;
        end
        got = 1'b0;
        while (cyc <= 20) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
            end else begin
                x = sb.pop_front();
                check({tag, "_latency"}, 32'(cyc), 32'(x.lat));
                check({tag, "_R"},       32'(R),   32'(x.r));
                check({tag, "_CCR"},     32'(CCR), 32'(x.ccr));
                @(negedge clk);
                start = 1'b0;
                check({tag, "_idle_busy"}, 32'(busy), 32'd0);
                check({tag, "_idle_done"}, 32'(done), 32'd0);
                check({tag, "_hold_R"},    32'(R),    32'(x.r));
                check({tag, "_hold_CCR"},  32'(CCR),  32'(x.ccr));
            end
        end else begin
            start = 1'b0;
            rst   = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            sb.delete();
        end
    endtask

    initial begin
        bit saw_done;

        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_R",    32'(R),    32'd0);
        check("rst_CCR",  32'(CCR),  32'd0);
        rst = 1'b0;

        // directed vectors, back-to-back
        do_op("logical",  4'b1011, 3'd1, 1'b0, 1'b0, 1'b0);
        do_op("arith",    4'b1011, 3'd2, 1'b1, 1'b0, 1'b0);
        do_op("zero_amt", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0);
        do_op("saturate", 4'b1001, 3'd7, 1'b0, 1'b0, 1'b0);
        do_op("rotate",   4'b0011, 3'd1, 1'b0, 1'b1, 1'b0);
        do_op("rot_sat",  4'b1010, 3'd6, 1'b1, 1'b1, 1'b0);
        do_op("arith_sat",4'b1000, 3'd5, 1'b1, 1'b0, 1'b0);

        // request while busy must not disturb the in-flight result
        do_op("busy_start", 4'b1101, 3'd3, 1'b0, 1'b0, 1'b1);

        // reset in cycle 2 of an amt=3 operation
        A = 4'b1101; amt = 3'd3; arith = 1'b0; rot = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_R",    32'(R),    32'd0);
        check("midrst_CCR",  32'(CCR),  32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);

        // random operations checked against the scoreboard
        for (int i = 0; i < 12; i++) begin
            do_op("random", 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shr_seq.md
Name: shr_seq

Overview:
- Sequential shift-right unit; the right-shift counterpart of the team's shift-left ALU op.
- Shifts operand A right by a variable amount, one bit position per clock, in logical or arithmetic mode.
- Produces result R and a 4-bit CCR (C,V,N,Z) at completion.
- Sits beside the other ALU op blocks and uses the same CCR bit layout and masks.

Parameters:
- OP_SIZE, 4: operand/result width in bits.
- CNT_W, 3: width of shift-amount port; must hold values 0..OP_SIZE.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- arith  input  1  0 = logical (MSB fills 0), 1 = arithmetic (MSB replicated).
- rot  input  1  rotate-right select; functional only with SHR_ROTATE_EN.
- amt  input  CNT_W  shift amount.
- A  input  OP_SIZE  operand.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse; R and CCR are valid from this cycle on.
- R  output  OP_SIZE  result.
- CCR  output  4  flags: bit3 = C (mask 1000), bit2 = V (0100), bit1 = N (0010), bit0 = Z (0001).

Behaviour:
- Reset: state IDLE; busy=0, done=0, R=0, CCR=0000; internal shift register and counter cleared.
- Reset asserted mid-operation aborts it: no done pulse, outputs return to reset values on the next edge.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Latch A, arith, rot and cnt = min(amt, OP_SIZE). Amounts above OP_SIZE saturate to OP_SIZE.
  - Clear internal carry.
  - Next state is SHIFT if cnt > 0, otherwise DONE.
- SHIFT, each cycle:
  - carry <= reg[0].
  - reg <= reg >> 1, with the MSB filled by 0 (logical), reg[OP_SIZE-1] (arith), or reg[0] (rotate).
  - cnt <= cnt - 1. When cnt reaches 1, next state is DONE.
- DONE, single cycle:
  - done=1.
  - R = reg.
  - C = carry, i.e. the last bit shifted out; C=0 when the amount is 0.
  - N = R[MSB].
  - V = A[MSB] XOR R[MSB] (sign change).
  - Z = (R == 0).
  - Then return to IDLE.
- Latency: amount k (after saturation) gives done in cycle k+1 after the start edge.
- R and CCR hold their values in IDLE until the next completion or reset.
- start asserted while busy is ignored and is not queued.
- start may be asserted in the cycle immediately after done (back-to-back operation).
- rot has priority over arith when SHR_ROTATE_EN is defined.

Optional Feature:
- Macro: SHR_ROTATE_EN.
- Defined:
  - rot=1 selects rotate-right.
  - Saturation is still applied, so an amount of OP_SIZE returns A unchanged with C = A[OP_SIZE-1].
- Undefined:
  - rot is ignored; no rotate logic is synthesised.
  - Behaviour is identical to rot=0.

Decomposition:
- Shared package shr_pkg:
  - CCR masks C_MASK, V_MASK, N_MASK, Z_MASK and CCR bit indices.
  - FSM state enum.
  - Default OP_SIZE.
- One sub-module, shr_ccr_calc: combinational computation of C, V, N and Z from A[MSB], the final register value and the carry. It is reusable by other ALU ops.

Test Plan:
- Logical shift: A=1011, amt=1, arith=0 -> done in cycle 2, R=0101, CCR=1100.
- Arithmetic shift: A=1011, amt=2, arith=1 -> done in cycle 3, R=1110, CCR=1010.
- Zero amount: A=0000, amt=0 -> done in cycle 1, R=0000, CCR=0001.
- Saturation: A=1001, amt=7, logical -> 4 shifts, done in cycle 5, R=0000, CCR=1101.
- Rotate (SHR_ROTATE_EN defined): A=0011, amt=1, rot=1 -> R=1001, CCR=1110.
  - Same stimulus without the macro -> R=0001, CCR=1000.
- Robustness:
  - start during busy: no effect on the in-flight result.
  - rst in cycle 2 of an amt=3 operation: next cycle busy=0, R=0000, CCR=0000, and no done pulse.
